// File: rtl/store_check_pkg.sv
// Shared types and default constants for the store result checker.
package store_check_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   localparam logic [ADDR_W-1:0] DEF_EXP_ADDR    = 32'd100;
   localparam logic [DATA_W-1:0] DEF_EXP_DATA    = 32'd25;
   localparam logic [ADDR_W-1:0] DEF_IGNORE_ADDR = 32'd96;
   localparam logic [31:0]       DEF_TIMEOUT     = 32'd1000;
   localparam int unsigned       DEF_LOG_DEPTH   = 8;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PASS    = 2'd1,
      FAIL    = 2'd2,
      TIMEOUT = 2'd3
   } check_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } store_entry_t;

endpackage

// File: rtl/store_log_fifo.sv
// First-word fall-through log of sampled stores with a sticky overflow flag.
module store_log_fifo
   import store_check_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_LOG_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  store_entry_t push_entry,
   input  logic         pop,
   output store_entry_t head,
   output logic         empty,
   output logic         overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   store_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic          overflow_q;
   logic          full;
   logic          pop_ok;
   logic          push_ok;

   // Extra pointer bit separates full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !push_ok) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
   end

   // Head reads as zero while empty so stale storage never leaks out.
   assign head     = empty ? store_entry_t'('0) : mem_q[rd_ptr_q[AW-1:0]];
   assign overflow = overflow_q;

endmodule

// File: rtl/store_result_checker.sv
// Watches the core's store bus and decides pass/fail/timeout of a self-checking program.
module store_result_checker
   import store_check_pkg::*;
#(
   parameter logic [31:0] EXP_ADDR       = DEF_EXP_ADDR,
   parameter logic [31:0] EXP_DATA       = DEF_EXP_DATA,
   parameter logic [31:0] IGNORE_ADDR    = DEF_IGNORE_ADDR,
   parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT,
   parameter int unsigned LOG_DEPTH      = DEF_LOG_DEPTH
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAddress,
   input  logic [31:0] WriteData,
   input  logic        log_rd_en,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [15:0] store_count,
   output logic [31:0] cycle_count,
   output logic        log_valid,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic        log_overflow
);

   check_state_t state_q, state_d;
   logic [15:0]  store_count_q, store_count_d;
   logic [31:0]  cycle_count_q, cycle_count_d;
   logic         done_q, pass_q, fail_q, timeout_q;
   logic         sample;
   logic         log_empty;
   store_entry_t log_head;

   always_comb begin
      state_d       = state_q;
      store_count_d = store_count_q;
      cycle_count_d = cycle_count_q;
      sample        = 1'b0;
      if (state_q == RUN) begin
         cycle_count_d = cycle_count_q + 32'd1;
         if (MemWrite) begin
            sample = 1'b1;
            if (store_count_q != 16'hFFFF) store_count_d = store_count_q + 16'd1;
            if (DataAddress == EXP_ADDR)
               state_d = (WriteData == EXP_DATA) ? PASS : FAIL;
            else if (DataAddress != IGNORE_ADDR)
               state_d = FAIL;
         end
         // A terminating store on this edge outranks the timeout.
         if (state_d == RUN && TIMEOUT_CYCLES != 32'd0 &&
             cycle_count_q == TIMEOUT_CYCLES - 32'd1)
            state_d = TIMEOUT;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= RUN;
         store_count_q <= '0;
         cycle_count_q <= '0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         store_count_q <= store_count_d;
         cycle_count_q <= cycle_count_d;
         done_q        <= (state_d != RUN);
         pass_q        <= (state_d == PASS);
         fail_q        <= (state_d == FAIL);
         timeout_q     <= (state_d == TIMEOUT);
      end
   end

   store_log_fifo #(
      .DEPTH (LOG_DEPTH)
   ) u_log (
      .clk        (clk),
      .rst        (Reset),
      .push       (sample),
      .push_entry ('{addr: DataAddress, data: WriteData}),
      .pop        (log_rd_en),
      .head       (log_head),
      .empty      (log_empty),
      .overflow   (log_overflow)
   );

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign store_count = store_count_q;
   assign cycle_count = cycle_count_q;
   assign log_valid   = !log_empty;
   assign log_addr    = log_head.addr;
   assign log_data    = log_head.data;

endmodule

// File: tb/tb_store_result_checker.sv
// Randomized and directed bench for store_result_checker against a queue-based reference model.
module tb_store_result_checker;

   localparam logic [31:0] TO    = 32'd16;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAddress = '0;
   logic [31:0] WriteData = '0;
   logic        log_rd_en = 1'b0;
   logic        done, pass, fail, timeout;
   logic [15:0] store_count;
   logic [31:0] cycle_count;
   logic        log_valid;
   logic [31:0] log_addr, log_data;
   logic        log_overflow;

   int total = 0;
   int bad   = 0;

   // Reference model: 0=running, 1=pass, 2=fail, 3=timeout
   int          m_state;
   logic [31:0] m_cyc;
   logic [15:0] m_cnt;
   logic        m_ovf;
   logic [63:0] m_q[$];

   store_result_checker #(
      .TIMEOUT_CYCLES (TO),
      .LOG_DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .Reset        (Reset),
      .MemWrite     (MemWrite),
      .DataAddress  (DataAddress),
      .WriteData    (WriteData),
      .log_rd_en    (log_rd_en),
      .done         (done),
      .pass         (pass),
      .fail         (fail),
      .timeout      (timeout),
      .store_count  (store_count),
      .cycle_count  (cycle_count),
      .log_valid    (log_valid),
      .log_addr     (log_addr),
      .log_data     (log_data),
      .log_overflow (log_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state = 0;
      m_cyc   = '0;
      m_cnt   = '0;
      m_ovf   = 1'b0;
      m_q.delete();
   endfunction

   function automatic void model_edge(input logic mw, input logic [31:0] a, input logic [31:0] d,
                                      input logic rd);
      logic [31:0] cyc_before;
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      if (m_state != 0) return;
      cyc_before = m_cyc;
      m_cyc = m_cyc + 32'd1;
      if (mw) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_q.size() < DEPTH) m_q.push_back({a, d});
         else m_ovf = 1'b1;
      end
      if (mw && a == 32'd100)      m_state = (d == 32'd25) ? 1 : 2;
      else if (mw && a != 32'd96)  m_state = 2;
      else if (cyc_before == TO - 32'd1) m_state = 3;
   endfunction

   task automatic check_all();
      chk_eq("done",     32'(done),     32'(m_state != 0));
      chk_eq("pass",     32'(pass),     32'(m_state == 1));
      chk_eq("fail",     32'(fail),     32'(m_state == 2));
      chk_eq("timeout",  32'(timeout),  32'(m_state == 3));
      chk_eq("stores",   32'(store_count), 32'(m_cnt));
      chk_eq("cycles",   cycle_count,   m_cyc);
      chk_eq("overflow", 32'(log_overflow), 32'(m_ovf));
      chk_eq("valid",    32'(log_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk_eq("log_addr", log_addr, m_q[0][63:32]);
         chk_eq("log_data", log_data, m_q[0][31:0]);
      end
   endtask

   task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rd);
      MemWrite    = mw;
      DataAddress = a;
      WriteData   = d;
      log_rd_en   = rd;
      @(posedge clk);
      model_edge(mw, a, d, rd);
      #1;
      check_all();
      MemWrite  = 1'b0;
      log_rd_en = 1'b0;
   endtask

   // Asynchronous assertion mid-cycle; outputs must clear before the next edge.
   task automatic apply_reset();
      @(negedge clk);
      Reset     = 1'b1;
      MemWrite  = 1'b0;
      log_rd_en = 1'b0;
      #1;
      model_reset();
      check_all();
      chk_eq("rst_log_addr", log_addr, 32'd0);
      chk_eq("rst_log_data", log_data, 32'd0);
      @(posedge clk);
      #1;
      check_all();
      Reset = 1'b0;
   endtask

   task automatic pass_sequence();
      step(1'b1, 32'd96, 32'd7, 1'b0);
      step(1'b1, 32'd96, 32'd9, 1'b0);
      step(1'b1, 32'd100, 32'd25, 1'b0);
      chk_eq("seq_pass", 32'(pass), 32'd1);
      chk_eq("seq_cnt", 32'(store_count), 32'd3);
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
      chk_eq("seq_drained", 32'(log_valid), 32'd0);
   endtask

   initial begin
      logic        mw, rd;
      logic [31:0] a, d;
      int          sel;
      model_reset();

      apply_reset();
      pass_sequence();

      apply_reset();
      step(1'b1, 32'd104, 32'd25, 1'b0);
      chk_eq("bad_addr_fail", 32'(fail), 32'd1);
      step(1'b0, 32'd0, 32'd0, 1'b0);
      step(1'b1, 32'd100, 32'd25, 1'b0);
      chk_eq("sticky_cnt", 32'(store_count), 32'd1);

      apply_reset();
      step(1'b1, 32'd100, 32'd24, 1'b0);
      chk_eq("bad_data_fail", 32'(fail), 32'd1);

      apply_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
      chk_eq("to_flag", 32'(timeout), 32'd1);
      chk_eq("to_frozen", cycle_count, 32'd16);

      apply_reset();
      for (int i = 0; i < 15; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
      step(1'b1, 32'd100, 32'd25, 1'b0);
      chk_eq("edge_pass", 32'(pass), 32'd1);
      chk_eq("edge_no_to", 32'(timeout), 32'd0);

      apply_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 32'd96, 32'(i), 1'b0);
      chk_eq("ovf_set", 32'(log_overflow), 32'd1);
      step(1'b1, 32'd96, 32'd123, 1'b1);
      chk_eq("ovf_head", log_data, 32'd1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1);

      apply_reset();
      step(1'b1, 32'd96, 32'd1, 1'b0);
      step(1'b1, 32'd96, 32'd2, 1'b0);
      apply_reset();
      pass_sequence();

      for (int ep = 0; ep < 20; ep++) begin
         apply_reset();
         for (int c = 0; c < 40; c++) begin
            mw  = ($urandom_range(0, 9) < 4);
            sel = int'($urandom_range(0, 15));
            a   = (sel < 10) ? 32'd96 : (sel < 12) ? 32'd100 : (sel < 14) ? 32'd104 : $urandom;
            d   = ($urandom_range(0, 1) == 1) ? 32'd25 : 32'($urandom_range(0, 40));
            rd  = ($urandom_range(0, 3) == 0);
            step(mw, a, d, rd);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
